// File: rtl/mgmt_tx_frame_buffer.sv
// rtl/mgmt_tx_frame_buffer.sv - store-and-forward transmit frame buffer for the management MAC
//
// Purpose: bytes pushed from the register side are packed MSB-first into
// 32-bit words and held in RAM. A frame becomes visible to the transmit side
// only when it is committed. The frame is then replayed word by word onto the
// MAC transmit bus once the MAC reports ready.
// Optional macro: MGMT_TX_PADDING_EN pads frames shorter than 60 bytes with
// zero words on the output side.
//
// Ports:
//   clk, rst            TX clock, synchronous active-high reset
//   wr_en, wr_data      push one byte
//   wr_commit, wr_drop  close (commit) or abort the frame being written
//   wr_free_words       free RAM words; in-progress words count as used
//   wr_overflow         sticky lost-byte / lost-commit flag
//   frames_pending      committed frames not yet fully sent
//   tx_ready            MAC can take a new frame
//   tx_bus_*            start strobe, data valid, bytes valid, data word
module mgmt_tx_frame_buffer #(
  parameter int DEPTH_WORDS     = 512,
  parameter int MAX_FRAMES      = 16,
  parameter int MAX_FRAME_BYTES = 1536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_commit,
  input  logic                          wr_drop,
  output logic [$clog2(DEPTH_WORDS):0]  wr_free_words,
  output logic                          wr_overflow,
  output logic [$clog2(MAX_FRAMES):0]   frames_pending,
  input  logic                          tx_ready,
  output logic                          tx_bus_start,
  output logic                          tx_bus_data_valid,
  output logic [2:0]                    tx_bus_bytes_valid,
  output logic [31:0]                   tx_bus_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int FW = $clog2(MAX_FRAMES);
  localparam int CW = $clog2(DEPTH_WORDS * 4) + 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA} state_t;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [CW-1:0] lf_mem [MAX_FRAMES];

  // Write side state
  logic [31:0]   stage_q, stage_n, wdata;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [AW:0]   spec_ptr, commit_ptr, spec_n, used;
  logic          poison_q, byte_lost, do_write, push, rewind, commit_lost;
  logic [FW:0]   lf_wr, lf_rd;
  logic          lf_full, lf_empty;

  // Read side state
  state_t        state;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] rd_idx, remaining, head_len, real_words, tot_words;
  logic [2:0]    last_bv;
  logic          rd_en, pad_zero;
  logic [AW-1:0] rd_addr;
  logic [31:0]   ram_q;

  // A partially filled staging word already owns its RAM slot.
  assign used           = (spec_ptr - rd_ptr) + {{AW{1'b0}}, (cnt_q[1:0] != 2'd0)};
  assign wr_free_words  = DEPTH_W - used;
  assign frames_pending = lf_wr - lf_rd;
  assign lf_full        = (frames_pending == (FW + 1)'(MAX_FRAMES));
  assign lf_empty       = (frames_pending == '0);

  always_comb begin
    stage_n     = stage_q;
    cnt_n       = cnt_q;
    spec_n      = spec_ptr;
    wdata       = '0;
    do_write    = 1'b0;
    byte_lost   = 1'b0;
    push        = 1'b0;
    rewind      = 1'b0;
    commit_lost = 1'b0;
    if (wr_en && !wr_drop && !poison_q) begin
      // Only the first byte of a word needs a fresh RAM slot.
      if (cnt_q[1:0] == 2'd0 && wr_free_words == '0) begin
        byte_lost = 1'b1;
      end else begin
        stage_n = {stage_q[23:0], wr_data};
        cnt_n   = cnt_q + CW'(1);
        if (cnt_n[1:0] == 2'd0) begin
          do_write = 1'b1;
          wdata    = stage_n;
          spec_n   = spec_ptr + (AW + 1)'(1);
        end
      end
    end
    if (wr_drop) begin
      rewind = 1'b1;
    end else if (wr_commit) begin
      if (poison_q || byte_lost) begin
        rewind = 1'b1;
      end else if (cnt_n == '0) begin
        rewind = 1'b0;
      end else if (int'(cnt_n) > MAX_FRAME_BYTES) begin
        rewind = 1'b1;
      end else if (lf_full) begin
        rewind      = 1'b1;
        commit_lost = 1'b1;
      end else begin
        push = 1'b1;
        if (cnt_n[1:0] != 2'd0) begin
          // Left-justify the tail bytes and zero-fill the rest.
          do_write = 1'b1;
          spec_n   = spec_ptr + (AW + 1)'(1);
          case (cnt_n[1:0])
            2'd1:    wdata = {stage_n[7:0], 24'h0};
            2'd2:    wdata = {stage_n[15:0], 16'h0};
            default: wdata = {stage_n[23:0], 8'h0};
          endcase
        end
      end
    end
  end

  // Both the full-word and the tail write land at the current speculative slot.
  always_ff @(posedge clk) begin
    if (do_write) ram[spec_ptr[AW-1:0]] <= wdata;
    if (push) lf_mem[lf_wr[FW-1:0]] <= cnt_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      cnt_q       <= '0;
      spec_ptr    <= '0;
      commit_ptr  <= '0;
      poison_q    <= 1'b0;
      lf_wr       <= '0;
      wr_overflow <= 1'b0;
    end else begin
      stage_q <= stage_n;
      if (byte_lost || commit_lost) wr_overflow <= 1'b1;
      if (rewind) begin
        spec_ptr <= commit_ptr;
        cnt_q    <= '0;
        poison_q <= 1'b0;
      end else if (push) begin
        spec_ptr   <= spec_n;
        commit_ptr <= spec_n;
        cnt_q      <= '0;
        poison_q   <= 1'b0;
        lf_wr      <= lf_wr + (FW + 1)'(1);
      end else begin
        spec_ptr <= spec_n;
        cnt_q    <= cnt_n;
        if (byte_lost) poison_q <= 1'b1;
      end
    end
  end

  assign head_len   = lf_mem[lf_rd[FW-1:0]];
  assign real_words = (head_len + CW'(3)) >> 2;

`ifdef MGMT_TX_PADDING_EN
  always_comb begin
    if (head_len < CW'(60)) begin
      tot_words = CW'(15);
      last_bv   = 3'd4;
    end else begin
      tot_words = real_words;
      last_bv   = (head_len[1:0] == 2'd0) ? 3'd4 : {1'b0, head_len[1:0]};
    end
  end
`else
  assign tot_words = real_words;
  assign last_bv   = (head_len[1:0] == 2'd0) ? 3'd4 : {1'b0, head_len[1:0]};
`endif

  // Reads are issued one cycle ahead of the word appearing on the bus.
  assign rd_en    = (state == S_START) || (state == S_DATA && remaining != '0);
  assign rd_addr  = rd_ptr[AW-1:0] + rd_idx[AW-1:0];
  assign pad_zero = (rd_idx >= real_words);

  // Output register of the RAM; held at zero whenever no word is being read.
  always_ff @(posedge clk) begin
    if (rst || !rd_en || pad_zero) ram_q <= '0;
    else ram_q <= ram[rd_addr];
  end
  assign tx_bus_data = ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      tx_bus_start       <= 1'b0;
      tx_bus_data_valid  <= 1'b0;
      tx_bus_bytes_valid <= 3'd0;
      rd_ptr             <= '0;
      lf_rd              <= '0;
      rd_idx             <= '0;
      remaining          <= '0;
    end else begin
      tx_bus_start <= 1'b0;
      case (state)
        S_IDLE: begin
          rd_idx             <= '0;
          tx_bus_data_valid  <= 1'b0;
          tx_bus_bytes_valid <= 3'd0;
          if (!lf_empty && tx_ready) begin
            state        <= S_START;
            tx_bus_start <= 1'b1;
          end
        end
        S_START: begin
          state              <= S_DATA;
          rd_idx             <= CW'(1);
          tx_bus_data_valid  <= 1'b1;
          tx_bus_bytes_valid <= (tot_words == CW'(1)) ? last_bv : 3'd4;
          remaining          <= tot_words - CW'(1);
        end
        default: begin
          if (remaining == '0) begin
            state              <= S_IDLE;
            tx_bus_data_valid  <= 1'b0;
            tx_bus_bytes_valid <= 3'd0;
            lf_rd              <= lf_rd + (FW + 1)'(1);
            rd_ptr             <= rd_ptr + real_words[AW:0];
          end else begin
            rd_idx             <= rd_idx + CW'(1);
            tx_bus_bytes_valid <= (remaining == CW'(1)) ? last_bv : 3'd4;
            remaining          <= remaining - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_tx_frame_buffer.sv
// tb/tb_mgmt_tx_frame_buffer.sv - scoreboard bench for mgmt_tx_frame_buffer
module tb_mgmt_tx_frame_buffer;

  logic        clk, rst;
  logic        wr_en, wr_commit, wr_drop, tx_ready;
  logic [7:0]  wr_data;
  logic [9:0]  wr_free_words;
  logic        wr_overflow;
  logic [4:0]  frames_pending;
  logic        tx_bus_start, tx_bus_data_valid;
  logic [2:0]  tx_bus_bytes_valid;
  logic [31:0] tx_bus_data;

  mgmt_tx_frame_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit), .wr_drop(wr_drop),
    .wr_free_words(wr_free_words), .wr_overflow(wr_overflow),
    .frames_pending(frames_pending), .tx_ready(tx_ready),
    .tx_bus_start(tx_bus_start), .tx_bus_data_valid(tx_bus_data_valid),
    .tx_bus_bytes_valid(tx_bus_bytes_valid), .tx_bus_data(tx_bus_data)
  );

  typedef struct {
    logic        start;
    logic [2:0]  bv;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_cyc = -100;
  int  cc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (tx_bus_start || tx_bus_data_valid)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: start=%0b valid=%0b data=%08h at cycle %0d, nothing expected",
                 tx_bus_start, tx_bus_data_valid, tx_bus_data, cyc);
      end else begin
        ev = exp_q.pop_front();
        check("start_flag", {31'b0, tx_bus_start}, {31'b0, ev.start});
        if (ev.start) begin
          check("idle_gap", {31'b0, (cyc - last_cyc >= 2)}, 32'd1);
          if (ev.cyc >= 0) check("start_cycle", 32'(cyc), 32'(ev.cyc));
        end else begin
          check("contiguous", 32'(cyc), 32'(last_cyc + 1));
          check("bytes_valid", {29'b0, tx_bus_bytes_valid}, {29'b0, ev.bv});
          check("data", tx_bus_data, ev.data);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic drive(input logic en, input logic [7:0] d, input logic commit, input logic drop);
    wr_en = en; wr_data = d; wr_commit = commit; wr_drop = drop;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_commit = 1'b0; wr_drop = 1'b0;
  endtask

  task automatic push_frame(input int n, input int base, input bit with_last, output int ccyc);
    ccyc = -1;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && with_last) ccyc = cyc;
      drive(1'b1, 8'((base + i) & 255), (i == n - 1) && with_last, 1'b0);
    end
    if (!with_last) begin
      ccyc = cyc;
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  // Expected frame built byte by byte from the pushed pattern.
  task automatic expect_frame(input int n, input int base, input int start_cyc);
    int padded, words, idx;
    ev_t e;
    padded = n;
`ifdef MGMT_TX_PADDING_EN
    if (padded < 60) padded = 60;
`endif
    words = (padded + 3) / 4;
    e.start = 1'b1; e.bv = 3'd0; e.data = 32'h0; e.cyc = start_cyc;
    exp_q.push_back(e);
    for (int k = 0; k < words; k++) begin
      e.start = 1'b0;
      e.cyc   = -1;
      e.data  = 32'h0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        e.data = {e.data[23:0], (idx < n) ? 8'((base + idx) & 255) : 8'h00};
      end
      if (k == words - 1) e.bv = ((padded % 4) == 0) ? 3'd4 : 3'(padded % 4);
      else e.bv = 3'd4;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_in_budget", {31'b0, (exp_q.size() == 0)}, 32'd1);
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; wr_commit = 1'b0; wr_drop = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_free_words", {22'b0, wr_free_words}, 32'd512);
    check("rst_overflow", {31'b0, wr_overflow}, 32'd0);
    check("rst_pending", {27'b0, frames_pending}, 32'd0);
    check("rst_start", {31'b0, tx_bus_start}, 32'd0);
    check("rst_valid", {31'b0, tx_bus_data_valid}, 32'd0);
    check("rst_bytes_valid", {29'b0, tx_bus_bytes_valid}, 32'd0);
    check("rst_data", tx_bus_data, 32'd0);

    // 64-byte frame, commit on the last byte.
    tx_ready = 1'b1;
    push_frame(64, 0, 1'b1, cc);
    expect_frame(64, 0, cc + 2);
    wait_drain(100);

    // 65-byte frame, commit in its own cycle.
    push_frame(65, 0, 1'b0, cc);
    expect_frame(65, 0, cc + 2);
    check("pending_after_commit", {27'b0, frames_pending}, 32'd1);
    wait_drain(100);
    check("pending_after_send", {27'b0, frames_pending}, 32'd0);
    check("free_after_send", {22'b0, wr_free_words}, 32'd512);

    // Short frame: 5 words, or 15 with padding.
    push_frame(20, 8'hA0, 1'b1, cc);
    expect_frame(20, 8'hA0, cc + 2);
    wait_drain(100);

    // Drop together with commit and a byte: nothing is sent.
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check("free_10_bytes", {22'b0, wr_free_words}, 32'd509);
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    check("free_after_drop", {22'b0, wr_free_words}, 32'd512);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    check("pending_after_drop", {27'b0, frames_pending}, 32'd0);

    // Oversize frame is discarded without setting the overflow flag.
    push_frame(1537, 7, 1'b1, cc);
    repeat (8) begin @(posedge clk); #1; end
    check("free_after_oversize", {22'b0, wr_free_words}, 32'd512);
    check("overflow_after_oversize", {31'b0, wr_overflow}, 32'd0);
    check("pending_after_oversize", {27'b0, frames_pending}, 32'd0);

    // Reset in the middle of a transmitted frame.
    push_frame(64, 9, 1'b1, cc);
    expect_frame(64, 9, cc + 2);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, tx_bus_data_valid}, 32'd0);
    check("midrst_data", tx_bus_data, 32'd0);
    do_reset();
    check("midrst_free", {22'b0, wr_free_words}, 32'd512);

    // Length FIFO full.
    tx_ready = 1'b0;
    for (int f = 0; f < 16; f++) begin
      push_frame(8, 16 * f, 1'b1, cc);
      expect_frame(8, 16 * f, -1);
    end
    check("fifo_full_pending", {27'b0, frames_pending}, 32'd16);
    check("fifo_full_no_ovf", {31'b0, wr_overflow}, 32'd0);
    push_frame(8, 8'hAA, 1'b1, cc);
    check("fifo_full_ovf", {31'b0, wr_overflow}, 32'd1);
    check("fifo_full_pending2", {27'b0, frames_pending}, 32'd16);
    check("fifo_full_free", {22'b0, wr_free_words}, 32'd480);
    tx_ready = 1'b1;
    wait_drain(200);
    check("fifo_drained", {27'b0, frames_pending}, 32'd0);

    // RAM full, overflow, then traffic across the pointer wrap.
    do_reset();
    tx_ready = 1'b1;
    push_frame(60, 5, 1'b1, cc);
    expect_frame(60, 5, cc + 2);
    wait_drain(100);
    tx_ready = 1'b0;
    push_frame(1024, 1, 1'b1, cc);
    expect_frame(1024, 1, -1);
    push_frame(1024, 2, 1'b1, cc);
    expect_frame(1024, 2, -1);
    check("ram_full_free", {22'b0, wr_free_words}, 32'd0);
    check("ram_full_no_ovf", {31'b0, wr_overflow}, 32'd0);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    check("ram_full_ovf", {31'b0, wr_overflow}, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("ram_full_pending", {27'b0, frames_pending}, 32'd2);
    tx_ready = 1'b1;
    wait_drain(1000);
    check("ram_empty_free", {22'b0, wr_free_words}, 32'd512);
    push_frame(1000, 3, 1'b1, cc);
    expect_frame(1000, 3, cc + 2);
    push_frame(1000, 4, 1'b0, cc);
    expect_frame(1000, 4, cc + 2);
    wait_drain(600);
    check("wrap_free", {22'b0, wr_free_words}, 32'd512);
    check("wrap_pending", {27'b0, frames_pending}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mgmt_tx_frame_buffer.md
Name: mgmt_tx_frame_buffer

Overview:
- Store-and-forward transmit buffer for the management Ethernet port; the outbound counterpart of the management RX frame FIFO.
- Accepts frame bytes pushed by the management register interface, already carried into the TX clock domain by an upstream CDC stage.
- Packs bytes into 32-bit words and holds each frame until it is committed.
- Then replays the frame onto the MAC transmit bus only when the MAC reports ready.

Parameters:
- DEPTH_WORDS, 512: data RAM depth in 32-bit words; power of 2.
- MAX_FRAMES, 16: committed-frame length FIFO depth; power of 2.
- MAX_FRAME_BYTES, 1536: frames committed with a larger byte count are discarded.

Ports:
- clk  in  1  TX clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  push one byte.
- wr_data  in  8  byte to push.
- wr_commit  in  1  end of current frame; frame becomes eligible for transmit.
- wr_drop  in  1  abort current uncommitted frame.
- wr_free_words  out  log2(DEPTH_WORDS)+1  free RAM words (committed plus in-progress frames counted as used).
- wr_overflow  out  1  sticky; set when a byte or commit is lost; cleared by rst only.
- frames_pending  out  log2(MAX_FRAMES)+1  committed frames not yet fully sent.
- tx_ready  in  1  MAC can accept a new frame (sampled only in IDLE).
- tx_bus_start  out  1  one-cycle frame start strobe.
- tx_bus_data_valid  out  1  tx_bus_data is valid.
- tx_bus_bytes_valid  out  3  valid bytes in word, 1..4, MSB-aligned.
- tx_bus_data  out  32  frame data, first byte in [31:24].

Behaviour:
- Reset (synchronous, active-high): clears all pointers, counters, FSM, wr_overflow. All outputs 0 except wr_free_words = DEPTH_WORDS.
- Write packing: bytes shift into a 32-bit staging word, MSB first. Every 4th byte writes the staging word to RAM at a speculative write pointer.
- wr_en and wr_commit in the same cycle: that byte is the last byte of the frame.
- Commit:
  - Partial staging word (1-3 bytes) is written zero-filled in the commit cycle.
  - Byte count is pushed to the length FIFO.
  - Committed write pointer advances to the speculative pointer.
- Commit of a 0-byte frame is ignored. Commit with count > MAX_FRAME_BYTES rewinds the speculative pointer (frame discarded, no flag).
- wr_drop: rewinds the speculative pointer and clears the byte count. wr_drop wins over a simultaneous wr_commit; the wr_en byte in that cycle is discarded.
- Overflow:
  - A byte that would need a RAM word while wr_free_words = 0 sets wr_overflow.
  - The current frame is then poisoned: further bytes are ignored, and its commit is treated as a drop.
  - Commit while the length FIFO is full sets wr_overflow and drops the frame.
- TX FSM:
  - IDLE: length FIFO non-empty and tx_ready=1 -> START.
  - START: tx_bus_start=1 for one cycle; issue first RAM read -> DATA.
  - DATA: one word per cycle, contiguous, no backpressure. tx_bus_bytes_valid=4 except on the last word (len mod 4, or 4 if 0). After the last word: pop length, advance read pointer -> IDLE.
- RAM has 1-cycle read latency; the read for word k+1 is issued in the cycle word k is output.
- Latency:
  - Commit in cycle N -> earliest tx_bus_start in N+2.
  - First data word in start+1; last word in start+ceil(len/4).
  - At least one idle cycle between frames.
- Pointer arithmetic: modulo DEPTH_WORDS with an extra wrap bit. Free-space computation correct across wraparound.
- Simultaneous read and write: a word written in cycle N is never read before N+2 (guaranteed by commit latency).
- Mid-transmit rst aborts the frame; outputs drop to 0 next cycle.

Optional Feature:
- Macro MGMT_TX_PADDING_EN.
- Defined: frames under 60 bytes are transmitted as 60 bytes. Bytes past the committed length are 0x00; the last word is bytes_valid=4 (15 words total). RAM usage is unchanged; padding is generated on the output side.
- Not defined: frames are sent at the committed length; the minimum-length rule is the software's responsibility.

Test Plan:
- Push 64 bytes 0x00..0x3F, commit, tx_ready=1 -> start 2 cycles after commit; then 16 contiguous words, first 0x00010203, last 0x3C3D3E3F, bytes_valid=4.
- Push 65 bytes, commit -> 17 words; last word 0x40000000 with bytes_valid=1; frames_pending 1->0 after last word.
- Push 10 bytes, then wr_drop and wr_commit together -> no tx_bus_start. wr_free_words returns to DEPTH_WORDS.
- Hold tx_ready=0, commit 16 frames of 8 bytes, attempt a 17th commit -> wr_overflow=1, frames_pending=16. Release tx_ready -> exactly 16 frames sent, each 2 words, at least one idle cycle apart.
- Fill RAM to wr_free_words=0, push one more byte then commit -> wr_overflow=1, frame not sent. Pointers wrap correctly on the next 2000-byte-total traffic.
- With MGMT_TX_PADDING_EN: commit 20-byte frame -> 15 words, words 6..15 = 0x00000000, final bytes_valid=4. Without the macro: 5 words.
